// File: rtl/alu_pkg.sv
// Shared ALU opcodes, branch funct3 encodings and resolver FSM states.
// Imported by the branch resolver and its condition decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    FOP_ADD  = 4'd0,
    FOP_SUB  = 4'd1,
    FOP_AND  = 4'd2,
    FOP_OR   = 4'd3,
    FOP_XOR  = 4'd4,
    FOP_SLL  = 4'd5,
    FOP_SRL  = 4'd6,
    FOP_SRA  = 4'd7,
    FOP_SLT  = 4'd8,
    FOP_SLTU = 4'd9,
    FOP_IMM  = 4'd10
  } fop_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } branch_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from the flags of an rs1-rs2 subtraction.
// Unsigned compare uses operand MSBs when the signs differ.
module branch_cond
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       rs1_msb,
  input  logic       rs2_msb,
  output logic       taken,
  output logic       illegal
);

  logic lt;
  logic ltu;

  assign lt  = n ^ v;
  assign ltu = (rs1_msb != rs2_msb) ? rs2_msb : n;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == F3_BEQ):  taken = z;
      (funct3 == F3_BNE):  taken = !z;
      (funct3 == F3_BLT):  taken = lt;
      (funct3 == F3_BGE):  taken = !lt;
      (funct3 == F3_BLTU): taken = ltu;
      (funct3 == F3_BGEU): taken = !ltu;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves one conditional branch at a time using an external ALU compare.
// Request -> EXEC (one ALU SUB cycle) -> RESP held until consumed.
module branch_resolver
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  output logic [XLEN-1:0] alu_rda,
  output logic [XLEN-1:0] alu_rdb,
  output logic [3:0]      alu_fop,
  input  logic            alu_Z,
  input  logic            alu_N,
  input  logic            alu_V,
  input  logic            alu_C,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_taken,
  output logic [XLEN-1:0] res_target,
  output logic            res_illegal
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  branch_state_t   state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic            valid_q, valid_d;

  logic [2:0] cond_f3;
  logic       cond_taken;
  logic       cond_illegal;
  logic       unused_carry;

  // Unsigned compare is derived from N and the MSBs, so carry is not needed.
  assign unused_carry = alu_C;

  // Legality is judged on the incoming funct3; taken on the registered one.
  assign cond_f3 = (state_q == EXEC) ? f3_q : br_funct3;

  branch_cond u_cond (
    .funct3  (cond_f3),
    .z       (alu_Z),
    .n       (alu_N),
    .v       (alu_V),
    .rs1_msb (rs1_q[XLEN-1]),
    .rs2_msb (rs2_q[XLEN-1]),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign br_ready    = (state_q == IDLE);
  assign res_valid   = valid_q;
  assign res_taken   = taken_q;
  assign res_target  = target_q;
  assign res_illegal = illegal_q;

  always_comb begin
    alu_fop = FOP_ADD;
    alu_rda = '0;
    alu_rdb = '0;
    if (state_q == EXEC) begin
      alu_fop = FOP_SUB;
      alu_rda = rs1_q;
      alu_rdb = rs2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    target_d  = target_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          f3_d  = br_funct3;
          rs1_d = br_rs1;
          rs2_d = br_rs2;
          pc_d  = br_pc;
          imm_d = br_imm;
          if (cond_illegal) begin
            state_d   = RESP;
            illegal_d = 1'b1;
            taken_d   = 1'b0;
            target_d  = br_pc + STEP;
            valid_d   = 1'b1;
          end else begin
            state_d   = EXEC;
            illegal_d = 1'b0;
          end
        end
      end
      EXEC: begin
        state_d  = RESP;
        taken_d  = cond_taken;
        target_d = cond_taken ? (pc_q + imm_q) : (pc_q + STEP);
        valid_d  = 1'b1;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Issues a compare to the RV32 ALU and resolves conditional branches from the ALU's flags.
- Drives the ALU operand/opcode inputs (rda, rdb, fop) and consumes its Z/N/V flags.
- Sits between decode and PC-update.
- Accepts one branch request at a time over a valid/ready handshake and returns taken/target over a second valid/ready handshake.

Parameters:
- XLEN, 32, data/address width
- PC_STEP, 4, sequential PC increment for a not-taken branch

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous active-low reset
- br_valid  input  1  branch request valid
- br_ready  output  1  block can accept a request (high only in IDLE)
- br_funct3  input  3  RV32 branch funct3
- br_rs1  input  XLEN  operand rs1
- br_rs2  input  XLEN  operand rs2
- br_pc  input  XLEN  PC of the branch instruction
- br_imm  input  XLEN  sign-extended B-type immediate
- alu_rda  output  XLEN  ALU operand A
- alu_rdb  output  XLEN  ALU operand B
- alu_fop  output  4  ALU opcode
- alu_Z, alu_N, alu_V, alu_C  input  1 each  ALU flags (combinational from ALU)
- res_valid  output  1  resolution valid
- res_ready  input  1  consumer accepts the resolution
- res_taken  output  1  branch taken
- res_target  output  XLEN  next PC
- res_illegal  output  1  funct3 not a branch encoding

Behaviour:
- Reset (nrst low, asynchronous):
  - State goes to IDLE.
  - res_valid, res_taken and res_illegal are 0; res_target is 0.
  - All operand registers are 0.
  - alu_fop is FOP_ADD; alu_rda and alu_rdb are 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - br_ready=1.
  - On br_valid&&br_ready, register funct3, rs1, rs2, pc and imm.
  - For a legal funct3 (000, 001, 100, 101, 110, 111) go to EXEC.
  - For an illegal funct3 (010, 011) go directly to RESP with res_illegal=1, res_taken=0, res_target=pc+PC_STEP.
- EXEC (exactly 1 cycle):
  - alu_rda=rs1_q, alu_rdb=rs2_q, alu_fop=FOP_SUB.
  - At the clock edge, evaluate the condition from the ALU flags and the registered operand MSBs, register taken/target, and go to RESP.
- Outside EXEC, alu_fop=FOP_ADD and operands are 0, so no spurious compare is visible.
- Condition rules (alu_C is ignored):
  - BEQ: Z. BNE: !Z.
  - BLT: N^V. BGE: !(N^V).
  - BLTU: (rs1[31]!=rs2[31]) ? rs2[31] : N.
  - BGEU: the complement of BLTU.
- Target: taken gives pc+imm; not taken gives pc+PC_STEP. Both are modulo 2^XLEN, so wrap-around is silent.
- RESP:
  - res_valid=1, and outputs are held stable until res_ready.
  - On res_valid&&res_ready, go to IDLE and clear res_valid.
  - A new request is accepted no earlier than the following cycle, giving a throughput of 1 per 3 cycles.
- Latency: request accepted at edge t, EXEC during cycle t+1, res_valid high after edge t+2. An illegal request gives res_valid after edge t+1.
- br_valid outside IDLE is ignored because br_ready=0. Requests are never dropped or overwritten.
- Reset asserted in EXEC or RESP aborts the operation; there is no res_valid pulse afterwards.
- res_ready held high continuously means RESP lasts exactly 1 cycle.

Decomposition:
- Shared package alu_pkg:
  - fop_t enum (FOP_ADD..FOP_IMM, 4-bit)
  - branch funct3 constants (F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111)
  - branch_state_t enum (IDLE, EXEC, RESP)
- One combinational sub-module, branch_cond: inputs funct3, Z, N, V, rs1_msb, rs2_msb; outputs taken and illegal.
- The ALU is instantiated in the bench next to branch_resolver, not inside it.

Test Plan:
- BEQ, rs1=rs2=123456789, pc=0x100, imm=0x20, res_ready=1 -> alu_fop=FOP_SUB in EXEC; res_valid 2 cycles after accept, taken=1, target=0x120.
- BLT, rs1=-10, rs2=5 and BGE, rs1=0x7FFFFFFF, rs2=0xFFFFFFFF -> BLT taken=1; BGE taken=1 (the signed-overflow case N^V is exercised).
- BLTU, rs1=0xFFFFFFF0, rs2=5, pc=0x200 -> taken=0, target=0x204; then BGEU on the same operands -> taken=1.
- funct3=010 -> res_illegal=1, taken=0, target=pc+4, res_valid 1 cycle after accept, alu_fop stays FOP_ADD throughout.
- Backpressure: res_ready=0 for 5 cycles with br_valid held high -> outputs stable, br_ready=0, second request accepted only after the handshake completes.
- Wrap and reset:
  - BNE, rs1=1, rs2=2, pc=0xFFFFFFF0, imm=0x20 -> target=0x10.
  - nrst low during EXEC -> res_valid stays 0 and the block returns to IDLE with br_ready=1.
